// File: rtl/aemb_pkg.sv
// Shared encodings for the AEMB load/store path: sequencer states, access
// sizes and the big-endian byte-lane selects used by the bus and the load sizer.
package aemb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DWB  = 2'd1,
    ST_FSL  = 2'd2,
    ST_DONE = 2'd3
  } xbus_state_e;

  localparam logic [1:0] SIZ_B = 2'd0;
  localparam logic [1:0] SIZ_H = 2'd1;
  localparam logic [1:0] SIZ_W = 2'd2;

  // Lane 8 is the most significant byte: big-endian addressing.
  localparam logic [3:0] SEL_B0  = 4'h8;
  localparam logic [3:0] SEL_B1  = 4'h4;
  localparam logic [3:0] SEL_B2  = 4'h2;
  localparam logic [3:0] SEL_B3  = 4'h1;
  localparam logic [3:0] SEL_H0  = 4'hC;
  localparam logic [3:0] SEL_H2  = 4'h3;
  localparam logic [3:0] SEL_W   = 4'hF;
  localparam logic [3:0] SEL_FSL = 4'h0;

endpackage

// File: rtl/aemb_xbus_lane.sv
// Size + low address bits -> byte-lane select and misalignment flag.
// Purely combinational; shared with the store sizer.
module aemb_xbus_lane
  import aemb_pkg::*;
(
  input  logic [1:0] i_siz,
  input  logic [1:0] i_adr,
  output logic [3:0] o_sel,
  output logic       o_mis
);

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    o_sel = SEL_W;
    o_mis = 1'b0;
    case (i_siz)
      SIZ_B: begin
        case (i_adr)
          2'd0: o_sel = SEL_B0;
          2'd1: o_sel = SEL_B1;
          2'd2: o_sel = SEL_B2;
          2'd3: o_sel = SEL_B3;
        endcase
      end
      SIZ_H: begin
        o_sel = i_adr[1] ? SEL_H2 : SEL_H0;
        o_mis = i_adr[0];
      end
      // Word and the reserved code both behave as a full word.
      default: o_mis = (i_adr != 2'd0);
    endcase
  end

endmodule

// File: rtl/aemb_xbus_ctrl.sv
// Load/store bus sequencer: runs one DWB or FSL handshake per instruction and
// holds the pipeline (gena) until it completes, times out or is rejected.
module aemb_xbus_ctrl
  import aemb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int TMO = 255
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          req,
  input  logic          req_we,
  input  logic          req_fsl,
  input  logic          req_nblk,
  input  logic [1:0]    req_siz,
  input  logic [AW-1:0] req_adr,
  input  logic          dwb_ack_i,
  input  logic          fsl_ack_i,
  output logic [AW-3:0] dwb_adr_o,
  output logic [3:0]    dwb_sel_o,
  output logic          dwb_stb_o,
  output logic          dwb_wre_o,
  output logic          fsl_stb_o,
  output logic          fsl_wre_o,
  output logic [3:0]    rDWBSEL,
  output logic          gena,
  output logic          xerr,
  output logic          fsl_miss
);

  localparam logic [15:0] TMO_C = 16'(TMO);

  xbus_state_e r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_inc;
  logic        r_nblk;
  logic [3:0]  w_sel;
  logic        w_mis;
  logic        w_ack, w_tmo, w_miss, w_exit;
  logic        w_dwb_go, w_fsl_go, w_mis_go;

  aemb_xbus_lane u_lane (
    .i_siz (req_siz),
    .i_adr (req_adr[1:0]),
    .o_sel (w_sel),
    .o_mis (w_mis)
  );

  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign gena      = ((r_state == ST_IDLE) && !req) || (r_state == ST_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_tmo       = 1'b0;
    w_miss      = 1'b0;
    w_exit      = 1'b0;
    w_dwb_go    = 1'b0;
    w_fsl_go    = 1'b0;
    w_mis_go    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (req_fsl) begin
            w_fsl_go    = 1'b1;
            w_state_nxt = ST_FSL;
          end else if (w_mis) begin
            w_mis_go    = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_dwb_go    = 1'b1;
            w_state_nxt = ST_DWB;
          end
        end
      end
      ST_DWB, ST_FSL: begin
        // Only the ack of the bus actually strobed counts.
        w_ack  = (r_state == ST_DWB) ? dwb_ack_i : fsl_ack_i;
        w_tmo  = (TMO_C != 16'd0) && (w_cnt_inc == TMO_C) && !w_ack;
        w_miss = (r_state == ST_FSL) && r_nblk && !w_ack;
        w_exit = w_ack || w_tmo || w_miss;
        if (w_exit) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and the async reset
  // is in the sensitivity list, so strobes drop the instant grst rises.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_cnt     <= 16'd0;
      r_nblk    <= 1'b0;
      dwb_adr_o <= '0;
      dwb_sel_o <= 4'h0;
      dwb_stb_o <= 1'b0;
      dwb_wre_o <= 1'b0;
      fsl_stb_o <= 1'b0;
      fsl_wre_o <= 1'b0;
      rDWBSEL   <= 4'h0;
      xerr      <= 1'b0;
      fsl_miss  <= 1'b0;
    end else begin
      r_cnt    <= (r_state inside {ST_DWB, ST_FSL}) ? w_cnt_inc : 16'd0;
      fsl_miss <= w_miss;
      if (w_dwb_go) begin
        dwb_adr_o <= req_adr[AW-1:2];
        dwb_sel_o <= w_sel;
        dwb_stb_o <= 1'b1;
        dwb_wre_o <= req_we;
        rDWBSEL   <= w_sel;
      end
      if (w_fsl_go) begin
        fsl_stb_o <= 1'b1;
        fsl_wre_o <= req_we;
        r_nblk    <= req_nblk;
        rDWBSEL   <= SEL_FSL;
      end
      if (w_exit) begin
        dwb_stb_o <= 1'b0;
        dwb_wre_o <= 1'b0;
        fsl_stb_o <= 1'b0;
        fsl_wre_o <= 1'b0;
      end
      if (w_mis_go || w_tmo) xerr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aemb_xbus_ctrl.sv
// Directed bench for aemb_xbus_ctrl with TMO=8; inputs change 1 ns after the
// rising edge and outputs are compared 1 ns later.
module tb_aemb_xbus_ctrl;

  logic        gclk = 1'b0;
  logic        grst;
  logic        req, req_we, req_fsl, req_nblk;
  logic [1:0]  req_siz;
  logic [31:0] req_adr;
  logic        dwb_ack_i, fsl_ack_i;
  logic [29:0] dwb_adr_o;
  logic [3:0]  dwb_sel_o, rDWBSEL;
  logic        dwb_stb_o, dwb_wre_o, fsl_stb_o, fsl_wre_o;
  logic        gena, xerr, fsl_miss;

  int total = 0;
  int bad   = 0;
  int cnt;

  aemb_xbus_ctrl #(.AW(32), .TMO(8)) dut (
    .gclk      (gclk),
    .grst      (grst),
    .req       (req),
    .req_we    (req_we),
    .req_fsl   (req_fsl),
    .req_nblk  (req_nblk),
    .req_siz   (req_siz),
    .req_adr   (req_adr),
    .dwb_ack_i (dwb_ack_i),
    .fsl_ack_i (fsl_ack_i),
    .dwb_adr_o (dwb_adr_o),
    .dwb_sel_o (dwb_sel_o),
    .dwb_stb_o (dwb_stb_o),
    .dwb_wre_o (dwb_wre_o),
    .fsl_stb_o (fsl_stb_o),
    .fsl_wre_o (fsl_wre_o),
    .rDWBSEL   (rDWBSEL),
    .gena      (gena),
    .xerr      (xerr),
    .fsl_miss  (fsl_miss)
  );

  always #5 gclk = ~gclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic drive(input logic r, input logic we, input logic fsl, input logic nb,
                       input logic [1:0] siz, input logic [31:0] adr);
    req      = r;
    req_we   = we;
    req_fsl  = fsl;
    req_nblk = nb;
    req_siz  = siz;
    req_adr  = adr;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    grst = 1'b1;
    dwb_ack_i = 1'b0;
    fsl_ack_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    repeat (3) tick();
    check("rst_dwb_stb", dwb_stb_o, 0);
    check("rst_fsl_stb", fsl_stb_o, 0);
    check("rst_adr", dwb_adr_o, 0);
    check("rst_sel", dwb_sel_o, 0);
    check("rst_rsel", rDWBSEL, 0);
    check("rst_xerr", xerr, 0);
    check("rst_miss", fsl_miss, 0);
    check("rst_gena", gena, 1);
    grst = 1'b0;

    // Byte load at 0x1003, zero-wait ack.
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1003);
    #1 check("b_gena_req", gena, 0);
    tick();
    check("b_stb", dwb_stb_o, 1);
    check("b_sel", dwb_sel_o, 4'h1);
    check("b_adr", dwb_adr_o, 30'h400);
    check("b_wre", dwb_wre_o, 0);
    check("b_gena_dwb", gena, 0);
    dwb_ack_i = 1'b1;
    tick();
    dwb_ack_i = 1'b0;
    check("b_stb_done", dwb_stb_o, 0);
    check("b_gena_done", gena, 1);
    check("b_rsel_done", rDWBSEL, 4'h1);
    tick();
    // req was still high during DONE; it must not start a second access.
    check("b_done_req_ign", dwb_stb_o, 0);
    req = 1'b0;
    #1 check("b_gena_idle", gena, 1);

    // Half store at 0x2002, ack after 4 wait cycles.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h2002);
    tick();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      dwb_ack_i = (i == 4);
      cnt += int'(dwb_stb_o);
      check("h_adr", dwb_adr_o, 30'h800);
      check("h_wre", dwb_wre_o, 1);
      tick();
    end
    dwb_ack_i = 1'b0;
    check("h_stb_cycles", cnt, 5);
    check("h_sel", dwb_sel_o, 4'h3);
    check("h_stb_done", dwb_stb_o, 0);
    check("h_xerr", xerr, 0);
    check("h_gena_done", gena, 1);
    req = 1'b0;
    tick();

    // Non-blocking FSL get with no FSL ack; a stray DWB ack must not count.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 32'h0);
    tick();
    check("fn_stb", fsl_stb_o, 1);
    check("fn_wre", fsl_wre_o, 0);
    check("fn_rsel", rDWBSEL, 4'h0);
    check("fn_dwb_stb", dwb_stb_o, 0);
    dwb_ack_i = 1'b1;
    tick();
    dwb_ack_i = 1'b0;
    check("fn_stb_done", fsl_stb_o, 0);
    check("fn_miss", fsl_miss, 1);
    check("fn_gena_done", gena, 1);
    req = 1'b0;
    tick();
    check("fn_miss_pulse", fsl_miss, 0);

    // Blocking FSL put, ack in the third strobe cycle.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0);
    tick();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      fsl_ack_i = (i == 2);
      cnt += int'(fsl_wre_o);
      check("fp_stb", fsl_stb_o, 1);
      tick();
    end
    fsl_ack_i = 1'b0;
    check("fp_wre_cycles", cnt, 3);
    check("fp_wre_done", fsl_wre_o, 0);
    check("fp_miss", fsl_miss, 0);
    check("fp_gena_done", gena, 1);
    req = 1'b0;
    tick();

    // Misaligned word load at 0x0006.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0006);
    tick();
    check("m_stb", dwb_stb_o, 0);
    check("m_xerr", xerr, 1);
    check("m_gena_done", gena, 1);
    check("m_adr_kept", dwb_adr_o, 30'h800);
    req = 1'b0;
    tick();
    check("m_xerr_sticky", xerr, 1);

    // Reset in the middle of a word load; later ack is ignored.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0010);
    tick();
    check("r_stb_before", dwb_stb_o, 1);
    grst = 1'b1;
    #1;
    check("r_stb_async", dwb_stb_o, 0);
    check("r_xerr", xerr, 0);
    check("r_sel", dwb_sel_o, 0);
    req = 1'b0;
    #1 check("r_gena_idle", gena, 1);
    tick();
    grst = 1'b0;
    dwb_ack_i = 1'b1;
    tick();
    dwb_ack_i = 1'b0;
    check("r_ack_ign_stb", dwb_stb_o, 0);
    check("r_ack_ign_gena", gena, 1);
    check("r_ack_ign_xerr", xerr, 0);

    // Timeout: word load, ack never comes, TMO=8.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0020);
    tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cnt += int'(dwb_stb_o);
      check("t_gena_stall", gena, 0);
      tick();
    end
    check("t_stb_cycles", cnt, 8);
    check("t_stb_done", dwb_stb_o, 0);
    check("t_xerr", xerr, 1);
    check("t_gena_done", gena, 1);
    req = 1'b0;
    tick();
    check("t_idle_stb", dwb_stb_o, 0);
    check("t_idle_gena", gena, 1);
    check("t_xerr_sticky", xerr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
